// File: rtl/ring_pkg.sv
// Shared constants and FSM state encoding for the ring-buffer drain serializer.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package ring_pkg;

    // Start bit + data bits + stop bit on the serial line.
    localparam int FRAME_BITS = 10;
    // Payload width of one popped ring-buffer entry.
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/ring_drain_tx_if.sv
// Bundle of the ring-buffer read side and the serial line of ring_drain_tx.
// Latency: n/a (wiring only).
// Backpressure: fifo_empty/tx_enable gate pops; the serial side has no backpressure.
interface ring_drain_tx_if;
    import ring_pkg::*;

    logic                 tx_enable;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_rd_en;
    logic                 tx;
    logic                 busy;
    logic                 byte_done;

    // Serializer side: consumes ring-buffer status/data, drives the line.
    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd_en,
        output tx,
        output busy,
        output byte_done
    );

    // Environment side: ring buffer plus whatever watches the line.
    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  byte_done
    );

endinterface

// File: rtl/ring_drain_tx_bit_timer.sv
// Bit-period counter: tick is high on the last clk of each CLKS_PER_BIT period.
// Latency: first tick CLKS_PER_BIT-1 cycles after clear drops.
// Backpressure: none; clear holds the count at zero.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'(CLKS_PER_BIT - 1));

    // Count up each cycle, wrapping at the end of a bit period or on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ring_drain_tx.sv
// Pops one byte at a time from an upstream ring buffer and sends it as an 8N1 frame.
// Latency: tx falls 3 edges after non-empty is sampled in IDLE; frame is 10*CLKS_PER_BIT.
// Backpressure: no pop while tx_enable=0 or fifo_empty=1; a started frame always completes.
module ring_drain_tx
    import ring_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    ring_drain_tx_if.master bus
);

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_idx;
    logic                 tick;
    logic                 timer_clear;

    // The timer sits at zero through IDLE/POP/LOAD so START begins a fresh
    // period; afterwards its own wrap on tick restarts every following bit.
    assign timer_clear = (state == IDLE) || (state == POP) || (state == LOAD);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    // Decoded from flops only (state and timer count), so no input reaches it
    // combinationally; it marks the final cycle of the stop bit.
    assign bus.byte_done = (state == STOP) && tick;

    // Frame sequencer: pop, capture, then shift start/data/stop onto tx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_idx        <= '0;
            bus.tx         <= 1'b1;
            bus.fifo_rd_en <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tx_enable && !bus.fifo_empty) begin
                        state          <= POP;
                        bus.fifo_rd_en <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                POP: begin
                    bus.fifo_rd_en <= 1'b0;
                    state          <= LOAD;
                end
                LOAD: begin
                    // Ring buffer presents the popped entry this cycle.
                    shreg  <= bus.fifo_rdata;
                    bus.tx <= 1'b0;
                    state  <= START;
                end
                START: begin
                    if (tick) begin
                        bus.tx  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            bus.tx <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bus.tx  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.tx         <= 1'b1;
                    bus.fifo_rd_en <= 1'b0;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ring_drain_tx.md
RING_DRAIN_TX -- requirements
Module: ring_drain_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, number of clk cycles each serial bit is held; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tx_enable  input  1  high permits starting a new frame; low blocks new pops only.
REQ-005 fifo_empty  input  1  empty flag from the upstream ring buffer.
REQ-006 fifo_rdata  input  8  upstream read data, valid the cycle after a pop.
REQ-007 fifo_rd_en  output  1  pop request to the upstream ring buffer, one-cycle pulse.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 byte_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-011 The FSM SHALL use states IDLE, POP, LOAD, START, DATA, STOP.
REQ-012 IDLE -> POP at the rising edge where tx_enable=1 and fifo_empty=0 are sampled; otherwise IDLE holds.
REQ-013 fifo_rd_en SHALL be 1 exactly during the POP cycle and 0 in every other state.
REQ-014 POP -> LOAD unconditionally; in LOAD, fifo_rdata SHALL be captured into an 8-bit shift register at the edge leaving LOAD.
REQ-015 LOAD -> START unconditionally; tx SHALL go 0 from that edge, 3 edges after empty was sampled low.
REQ-016 START, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a bit counter cleared on every state entry.
REQ-017 DATA SHALL send 8 bits LSB first with a 3-bit bit index; after bit 7 go STOP.
REQ-018 STOP drives tx=1; at its last cycle byte_done=1 and the next state is IDLE.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles of tx activity; back-to-back frames have at least 3 idle-high cycles (IDLE, POP, LOAD) between stop end and next start.
REQ-020 tx_enable falling mid-frame SHALL NOT abort the frame; only the IDLE decision samples it.
REQ-021 fifo_empty and fifo_rdata SHALL be ignored outside IDLE and LOAD respectively; a pop sampled with stale non-empty flag yields whatever fifo_rdata holds, transmitted unmodified.
REQ-022 At most one pop SHALL be issued per frame; no second fifo_rd_en before byte_done.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, tx=1, fifo_rd_en=0, busy=0, byte_done=0, counters and shift register 0.
REQ-024 rst asserted mid-frame SHALL abandon the frame without a byte_done; the popped byte is lost.
REQ-025 After rst deassertion, the first pop SHALL occur no earlier than the first rising edge sampling fifo_empty=0.

Structure
REQ-026 State encoding, FRAME_BITS=10 and DATA_BITS=8 constants SHALL live in a shared package, ring_pkg.
REQ-027 The bit-period counter SHALL be a sub-module, bit_timer (inputs clk, rst, clear; output tick at count CLKS_PER_BIT-1).
REQ-028 Implementation target: 120-400 RTL lines, no memories, no combinational path input-to-output.

Verification
REQ-029 Single byte: CLKS_PER_BIT=4, FIFO holds 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; one fifo_rd_en pulse; one byte_done.
REQ-030 Back-to-back: FIFO holds 0x01, 0xFF -> two frames, exactly 3 tx-high cycles between first stop end and second start; bytes in order.
REQ-031 Enable gating: tx_enable=0 with FIFO non-empty -> no fifo_rd_en, tx stays 1; raise tx_enable -> pop on next edge.
REQ-032 Enable drop mid-frame: send 0x3C, drop tx_enable at bit 2 -> full frame completes, byte_done pulses, no further pop.
REQ-033 Reset mid-frame: rst at DATA bit 4 of 0x55 -> tx=1, busy=0 asynchronously; no byte_done; next byte 0x0F transmits correctly.
REQ-034 Wrap-around: 6 bytes 0x10..0x15 through a depth-4 ring buffer -> all 6 transmitted in order, 6 pops, 6 byte_done pulses.
